// File: rtl/aes_decrypt.sv
// AES-128 inverse cipher: one round per cycle, the key schedule is unwound on the fly.
// Optional rk10 key cache is built when AES_DECRYPT_KEYCACHE_EN is defined.
module aes_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         done,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, KEXP, ADD, ROUND} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse and conveniently maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Row r of output column c comes from input column (c - r) mod 4
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    t = t ^ k;
    if (mix)
      for (int c = 0; c < 4; c++)
        t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    return t;
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, ct_q, ct_d, prev_rk;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
`ifdef AES_DECRYPT_KEYCACHE_EN
  logic [127:0] ck_key_q, ck_key_d, ck_rk_q, ck_rk_d;
  logic         ck_vld_q, ck_vld_d;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    prev_rk = key_inv(rk_q, rcon(4'd9 - cnt_q));
`ifdef AES_DECRYPT_KEYCACHE_EN
    ck_key_d = ck_key_q;
    ck_rk_d  = ck_rk_q;
    ck_vld_d = ck_vld_q;
`endif
    case (fsm_q)
      IDLE: if (start) begin
        st_d  = plaintext;
        rk_d  = key;
        cnt_d = 4'd0;
        fsm_d = KEXP;
`ifdef AES_DECRYPT_KEYCACHE_EN
        if (ck_vld_q && key == ck_key_q) begin
          rk_d  = ck_rk_q;
          fsm_d = ADD;
        end else begin
          ck_key_d = key;
          ck_vld_d = 1'b0;
        end
`endif
      end
      KEXP: begin
        rk_d  = key_fwd(rk_q, rcon(cnt_q));
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          cnt_d = 4'd0;
          fsm_d = ADD;
`ifdef AES_DECRYPT_KEYCACHE_EN
          ck_rk_d  = rk_d;
          ck_vld_d = 1'b1;
`endif
        end
      end
      ADD: begin
        st_d  = st_q ^ rk_q;
        cnt_d = 4'd0;
        fsm_d = ROUND;
      end
      ROUND: begin
        st_d  = inv_round(st_q, prev_rk, cnt_q != 4'd9);
        rk_d  = prev_rk;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          ct_d   = st_d;
          done_d = 1'b1;
          cnt_d  = 4'd0;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      rk_q   <= '0;
      ct_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      rk_q   <= rk_d;
      ct_q   <= ct_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef AES_DECRYPT_KEYCACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_key_q <= '0;
      ck_rk_q  <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      ck_key_q <= ck_key_d;
      ck_rk_q  <= ck_rk_d;
      ck_vld_q <= ck_vld_d;
    end
  end
`endif

  assign ciphertext = ct_q;
  assign done       = done_q;
  assign busy       = (fsm_q != IDLE);
endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS vectors, round trips through a byte-level AES encrypt model.
module tb_aes_decrypt;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] plaintext, key, ciphertext;
  logic         done, busy;

  int vectors = 0;
  int miscompares = 0;

`ifdef AES_DECRYPT_KEYCACHE_EN
  localparam int LAT_REP = 11;
`else
  localparam int LAT_REP = 21;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_OUT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_IN   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_OUT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_decrypt dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext), .key(key),
    .ciphertext(ciphertext), .done(done), .busy(busy)
  );

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int x, y, p;
    x = a; y = b; p = 0;
    while (y != 0) begin
      if (y % 2 == 1) p = p ^ x;
      x = x * 2;
      if (x >= 256) x = x ^ 'h11b;
      y = y / 2;
    end
    return p[7:0];
  endfunction

  // S-box from brute-force inverse search plus the bitwise affine definition
  task automatic build_tables();
    logic [7:0] inv, s, c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sb[x] = s;
    end
  endtask

  task automatic m_encrypt(input logic [127:0] k, input logic [127:0] pt, output logic [127:0] ct);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      rk = {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] t);
    @(negedge clk);
    key = k; plaintext = t; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0; plaintext = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ciphertext !== 128'h0) begin
      miscompares++; $display("FAIL reset_ct: got %h want 0", ciphertext);
    end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_model();
    logic [127:0] ct;
    m_encrypt(C1_KEY, C1_OUT, ct);
    vectors++;
    if (ct !== C1_IN) begin miscompares++; $display("FAIL model_c1: got %h want %h", ct, C1_IN); end
  endtask

  task automatic test_fips_c1();
    logic [127:0] hold;
    int lat;
    do_start(C1_KEY, C1_IN);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL c1_busy: got %b want 1", busy); end
    wait_done(lat);
    vectors++;
    if (lat !== 21) begin miscompares++; $display("FAIL c1_latency: got %0d want 21", lat); end
    vectors++;
    if (ciphertext !== C1_OUT) begin
      miscompares++; $display("FAIL c1_result: got %h want %h", ciphertext, C1_OUT);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL c1_busy_at_done: got %b want 0", busy); end
    hold = ciphertext;
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL c1_done_width: got %b want 0", done); end
    vectors++;
    if (ciphertext !== C1_OUT) begin
      miscompares++; $display("FAIL c1_hold: got %h want %h", ciphertext, hold);
    end
  endtask

  task automatic test_fips_b();
    int lat;
    do_start(B_KEY, B_IN);
    wait_done(lat);
    vectors++;
    if (lat !== 21) begin miscompares++; $display("FAIL b_latency: got %0d want 21", lat); end
    vectors++;
    if (ciphertext !== B_OUT) begin
      miscompares++; $display("FAIL b_result: got %h want %h", ciphertext, B_OUT);
    end
  endtask

  task automatic test_roundtrip_hello();
    logic [127:0] k, pt, ct;
    int lat;
    k  = 128'h6b65790a;
    pt = 128'h48656c6c6f21;
    m_encrypt(k, pt, ct);
    do_start(k, ct);
    wait_done(lat);
    vectors++;
    if (ciphertext !== pt) begin
      miscompares++; $display("FAIL hello_result: got %h want %h", ciphertext, pt);
    end
  endtask

  task automatic test_random();
    logic [127:0] k, pt, ct;
    int lat;
    for (int n = 0; n < 6; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      m_encrypt(k, pt, ct);
      do_start(k, ct);
      @(negedge clk);
      key = {$urandom, $urandom, $urandom, $urandom};
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      wait_done(lat);
      vectors++;
      if (lat !== 21) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want 21", n, lat); end
      vectors++;
      if (ciphertext !== pt) begin
        miscompares++; $display("FAIL rand%0d_result: got %h want %h", n, ciphertext, pt);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, first, ndone;
    first = -1; ndone = 0;
    do_start(C1_KEY, C1_IN);
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) first = i;
      end
      if (i == 5) begin key = B_KEY; plaintext = B_IN; start = 1'b1; end
      if (i == 6) start = 1'b0;
    end
    vectors++;
    if (first !== 21) begin miscompares++; $display("FAIL b2b_latency: got %0d want 21", first); end
    vectors++;
    if (ndone !== 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 1", ndone); end
    vectors++;
    if (ciphertext !== C1_OUT) begin
      miscompares++; $display("FAIL b2b_result: got %h want %h", ciphertext, C1_OUT);
    end
    do_start(C1_KEY, C1_IN);
    wait_done(lat);
    vectors++;
    if (lat !== LAT_REP) begin miscompares++; $display("FAIL repeat_latency: got %0d want %0d", lat, LAT_REP); end
    vectors++;
    if (ciphertext !== C1_OUT) begin
      miscompares++; $display("FAIL repeat_result: got %h want %h", ciphertext, C1_OUT);
    end
    do_start(B_KEY, B_IN);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL next_accept_busy: got %b want 1", busy); end
    wait_done(lat);
    vectors++;
    if (lat !== 21) begin miscompares++; $display("FAIL next_latency: got %0d want 21", lat); end
    vectors++;
    if (ciphertext !== B_OUT) begin
      miscompares++; $display("FAIL next_result: got %h want %h", ciphertext, B_OUT);
    end
  endtask

  task automatic test_reset_mid();
    int lat, ndone;
    ndone = 0;
    do_start(C1_KEY, C1_IN);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (done) ndone++;
    vectors++;
    if (ndone !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    vectors++;
    if (ciphertext !== 128'h0) begin
      miscompares++; $display("FAIL abort_ct: got %h want 0", ciphertext);
    end
    rst = 1'b0;
    do_start(C1_KEY, C1_IN);
    wait_done(lat);
    vectors++;
    if (lat !== 21) begin miscompares++; $display("FAIL post_reset_latency: got %0d want 21", lat); end
    vectors++;
    if (ciphertext !== C1_OUT) begin
      miscompares++; $display("FAIL post_reset_result: got %h want %h", ciphertext, C1_OUT);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    test_reset();
    test_model();
    test_fips_c1();
    test_fips_b();
    test_roundtrip_hello();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL provide these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- plaintext  in  128  AES-128 ciphertext block to decrypt. The name mirrors the aes_encrypt port map.
- key  in  128  cipher key.
- ciphertext  out  128  decrypted block, registered.
- done  out  1  one-cycle pulse when ciphertext is updated.
- busy  out  1  high from the start-accept cycle until done.
REQ-003 Byte order SHALL be FIPS-197: bits [127:120] are byte 0; the state is column-major, so bytes 0-3 form column 0.

Function
REQ-004 The block SHALL compute FIPS-197 AES-128 InvCipher, i.e. the exact inverse of the team's aes_encrypt for the same key.
REQ-005 The FSM SHALL have four states, with these transitions:
- IDLE -> KEXP on start. On that edge, plaintext and key are captured into internal registers and busy is set.
- KEXP: 10 cycles of forward key expansion, one round key per cycle (rcon 01,02,04,08,10,20,40,80,1b,36), ending at rk10.
- ADD: 1 cycle; state ^= rk10.
- ROUND: 10 cycles, in this order:
  - Each cycle applies InvShiftRows, InvSubBytes, then AddRoundKey with the previous round key.
  - The previous round key is derived from the current one in the same cycle by inverse key expansion.
  - InvMixColumns is applied in the first 9 cycles only.
  - On the 10th edge: ciphertext <= result, done <= 1, busy <= 0, state -> IDLE.
REQ-006 Latency without a cache hit SHALL be 21 clock edges after the start-sampling edge, counted as 10 KEXP + 1 ADD + 10 ROUND edges.
REQ-007 Throughput SHALL be one block per 22 cycles; start SHALL be accepted again on the cycle after done.
REQ-008 start asserted while busy=1 SHALL be ignored. plaintext and key changes while busy SHALL NOT affect the result in progress.
REQ-009 ciphertext SHALL hold its last value until the next done. done SHALL be high for exactly one cycle.
REQ-010 InvSubBytes SHALL use the inverse AES S-box. Either a computed GF(2^8) inverse plus affine or a 256-entry table is permitted. The forward S-box needed for key expansion SHALL be an equivalent implementation.
REQ-011 GF(2^8) multiplication SHALL use the polynomial 0x11b. InvMixColumns SHALL use the coefficients 0e, 0b, 0d, 09.

Reset
REQ-012 While rst=1 at a rising edge, the block SHALL apply all of the following:
- state goes to IDLE.
- ciphertext=0, done=0, busy=0.
- internal state, round-key and counter registers are set to 0.
- the key cache valid flag (REQ-014) is cleared.
REQ-013 Reset mid-operation SHALL abort the operation with no done pulse. A start at the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-014 With AES_DECRYPT_KEYCACHE_EN defined, the block SHALL keep a cache consisting of the last key, its rk10, and a valid flag, with this behaviour:
- If a start's key equals the cached key and valid=1, KEXP SHALL be skipped, and latency SHALL be 11 edges (ADD + 10 ROUND).
- Otherwise the full 21-edge path SHALL run, and the cache SHALL be written at the end of KEXP.
REQ-015 Without AES_DECRYPT_KEYCACHE_EN, no cache storage SHALL exist and every operation SHALL take 21 edges. Results SHALL be identical in both builds.

Verification
REQ-016 The bench SHALL cover these scenarios:
- FIPS C.1: key=000102030405060708090a0b0c0d0e0f, plaintext=69c4e0d86a7b0430d8cdb78070b4c55a -> ciphertext=00112233445566778899aabbccddeeff, done exactly 21 edges after start.
- FIPS B: key=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3925841d02dc09fbdc118597196a0b32 -> ciphertext=3243f6a8885a308d313198a2e0370734.
- Round trip: a 48-bit "Hello!" (0x48656c6c6f21, zero-extended) with key 0x6b65790a, encrypted by aes_encrypt and then fed here -> ciphertext=0x...48656c6c6f21 (zero-extended).
- Back-to-back runs: start pulsed during busy -> ignored, single done. With AES_DECRYPT_KEYCACHE_EN, a repeat of the C.1 key -> done after 11 edges with the same result.
- Reset: rst asserted at ROUND cycle 5 -> no done; busy=0 and ciphertext=0 next cycle; a following C.1 run still takes 21 edges (cache cleared).
